// File: rtl/pci_target_devsel.sv
// PCI target front end: address-phase detect, multi-BAR decode, DEVSEL#/TRDY# timing, data-phase tracking.
// Optional first-phase retry (STOP#) when the macro PCI_TARGET_RETRY_EN is defined.
module pci_target_devsel #(
    parameter int                     NUM_BARS     = 2,
    parameter logic [NUM_BARS*32-1:0] BAR_BASE     = {32'h0000_2000, 32'h1000_0000},
    parameter logic [NUM_BARS*32-1:0] BAR_MASK     = {32'hFFFF_FF00, 32'hFFFF_0000},
    parameter int                     DEVSEL_SPEED = 0,
    parameter logic [15:0]            CMD_EN       = 16'h00CC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_n,
    input  logic                irdy_n,
    input  logic [31:0]         ad,
    input  logic [3:0]          cbe_n,
    input  logic                be_ready,
    output logic                devsel_n,
    output logic                trdy_n,
    output logic                stop_n,
    output logic [NUM_BARS-1:0] bar_hit,
    output logic [31:0]         addr_q,
    output logic [3:0]          cmd_q,
    output logic                data_xfer,
    output logic                busy
);

    // The illegal speed code 3 is treated as slow.
    localparam int         SPEED    = (DEVSEL_SPEED > 2) ? 2 : DEVSEL_SPEED;
    localparam logic [1:0] CNT_INIT = (SPEED > 0) ? 2'(SPEED - 1) : 2'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSY,
        S_WAIT,
        S_DATA,
        S_RETRY
    } state_t;

    state_t              state_q;
    logic                frame_q;
    logic [1:0]          cnt_q;
    logic                devsel_n_q;
    logic                trdy_n_q;
    logic [NUM_BARS-1:0] bar_hit_q;
    logic [NUM_BARS-1:0] hit_raw;
    logic [NUM_BARS-1:0] hit_onehot;
    logic                claim;
    logic                addr_phase;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BARS; gi++) begin : g_bar
            localparam logic [31:0] BASE = BAR_BASE[32*gi +: 32];
            localparam logic [31:0] MASK = BAR_MASK[32*gi +: 32];
            assign hit_raw[gi] = ((ad & MASK) == (BASE & MASK));
        end
    endgenerate

    // Isolate the lowest set bit so the lowest-index BAR wins overlapping windows.
    assign hit_onehot = hit_raw & (~hit_raw + NUM_BARS'(1));
    assign claim      = CMD_EN[cbe_n] & (|hit_raw);
    assign addr_phase = ~frame_n & frame_q;

    assign data_xfer = (state_q == S_DATA) & ~irdy_n & ~trdy_n_q;
    assign busy      = (state_q != S_IDLE);
    assign devsel_n  = devsel_n_q;
    assign trdy_n    = trdy_n_q;
    assign bar_hit   = bar_hit_q;

`ifdef PCI_TARGET_RETRY_EN
    logic       stop_n_q;
    logic       first_q;
    logic [3:0] rcnt_q;

    assign stop_n = stop_n_q;
`else
    assign stop_n = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            frame_q    <= 1'b1;
            cnt_q      <= 2'd0;
            devsel_n_q <= 1'b1;
            trdy_n_q   <= 1'b1;
            bar_hit_q  <= '0;
            addr_q     <= 32'd0;
            cmd_q      <= 4'd0;
`ifdef PCI_TARGET_RETRY_EN
            stop_n_q   <= 1'b1;
            first_q    <= 1'b0;
            rcnt_q     <= 4'd0;
`endif
        end else begin
            frame_q <= frame_n;
            case (state_q)
                S_IDLE: begin
                    if (addr_phase) begin
                        addr_q <= ad;
                        cmd_q  <= cbe_n;
                        if (claim) begin
                            bar_hit_q <= hit_onehot;
                            if (SPEED == 0) begin
                                devsel_n_q <= 1'b0;
                                state_q    <= S_DATA;
`ifdef PCI_TARGET_RETRY_EN
                                first_q    <= 1'b1;
                                rcnt_q     <= 4'd0;
`endif
                            end else begin
                                cnt_q   <= CNT_INIT;
                                state_q <= S_WAIT;
                            end
                        end else begin
                            state_q <= S_BUSY;
                        end
                    end
                end

                // Transaction owned by someone else; wait for the bus to go idle.
                S_BUSY: begin
                    if (frame_n && irdy_n) begin
                        state_q <= S_IDLE;
                    end
                end

                S_WAIT: begin
                    if (frame_n && irdy_n) begin
                        state_q    <= S_IDLE;
                        devsel_n_q <= 1'b1;
                        bar_hit_q  <= '0;
                    end else if (cnt_q == 2'd0) begin
                        devsel_n_q <= 1'b0;
                        state_q    <= S_DATA;
`ifdef PCI_TARGET_RETRY_EN
                        first_q    <= 1'b1;
                        rcnt_q     <= 4'd0;
`endif
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end

                S_DATA: begin
                    if (data_xfer) begin
                        addr_q <= addr_q + 32'd4;
                    end
                    if (data_xfer && frame_n) begin
                        trdy_n_q   <= 1'b1;
                        devsel_n_q <= 1'b1;
                        bar_hit_q  <= '0;
                        state_q    <= S_IDLE;
                    end
`ifdef PCI_TARGET_RETRY_EN
                    else if (first_q && !data_xfer && (rcnt_q == 4'hF)) begin
                        stop_n_q <= 1'b0;
                        trdy_n_q <= 1'b1;
                        state_q  <= S_RETRY;
                    end
`endif
                    else begin
                        trdy_n_q <= ~be_ready;
                    end
`ifdef PCI_TARGET_RETRY_EN
                    if (data_xfer) begin
                        first_q <= 1'b0;
                    end else if (first_q) begin
                        rcnt_q <= rcnt_q + 4'd1;
                    end
`endif
                end

`ifdef PCI_TARGET_RETRY_EN
                // Hold STOP# until the initiator drops FRAME#.
                S_RETRY: begin
                    if (frame_n) begin
                        stop_n_q   <= 1'b1;
                        devsel_n_q <= 1'b1;
                        bar_hit_q  <= '0;
                        first_q    <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
`endif

                default: begin
                    state_q    <= S_IDLE;
                    devsel_n_q <= 1'b1;
                    trdy_n_q   <= 1'b1;
                    bar_hit_q  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pci_target_devsel.sv
// Bench for pci_target_devsel: a fast (speed 0) and a slow (speed 2) target share AD/CBE/be_ready.
// Expected transfers are queued as stimulus is driven and popped by a monitor on each data_xfer.
module tb_pci_target_devsel;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_n, irdy_n, frame_ns, irdy_ns;
    logic [31:0] ad;
    logic [3:0]  cbe_n;
    logic        be_ready;

    logic        devsel_f, trdy_f, stop_f, xfer_f, busy_f;
    logic [1:0]  bar_f;
    logic [31:0] addr_f;
    logic [3:0]  cmd_f;
    logic        devsel_s, trdy_s, stop_s, xfer_s, busy_s;
    logic [1:0]  bar_s;
    logic [31:0] addr_s;
    logic [3:0]  cmd_s;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  bar;
    } xfer_t;

    xfer_t q_f[$];
    xfer_t q_s[$];
    xfer_t e_mon;

    always #5 clk = ~clk;

    pci_target_devsel #(.DEVSEL_SPEED(0)) dut_f (
        .clk(clk), .rst(rst), .frame_n(frame_n), .irdy_n(irdy_n), .ad(ad), .cbe_n(cbe_n),
        .be_ready(be_ready), .devsel_n(devsel_f), .trdy_n(trdy_f), .stop_n(stop_f),
        .bar_hit(bar_f), .addr_q(addr_f), .cmd_q(cmd_f), .data_xfer(xfer_f), .busy(busy_f)
    );

    pci_target_devsel #(.DEVSEL_SPEED(2)) dut_s (
        .clk(clk), .rst(rst), .frame_n(frame_ns), .irdy_n(irdy_ns), .ad(ad), .cbe_n(cbe_n),
        .be_ready(be_ready), .devsel_n(devsel_s), .trdy_n(trdy_s), .stop_n(stop_s),
        .bar_hit(bar_s), .addr_q(addr_s), .cmd_q(cmd_s), .data_xfer(xfer_s), .busy(busy_s)
    );

    // Scoreboard side: every observed transfer must match the oldest queued expectation.
    always @(negedge clk) begin
        if (xfer_f === 1'b1) begin
            n_tests++;
            if (q_f.size() == 0) begin
                n_fail++;
                $display("FAIL xfer_f_unexpected: got addr=%h bar=%b, expected no transfer", addr_f, bar_f);
            end else begin
                e_mon = q_f.pop_front();
                if ({addr_f, bar_f} !== {e_mon.addr, e_mon.bar}) begin
                    n_fail++;
                    $display("FAIL xfer_f: got addr=%h bar=%b, expected addr=%h bar=%b",
                             addr_f, bar_f, e_mon.addr, e_mon.bar);
                end else begin
                    $display("[TB] xfer fast addr=%h bar=%b", addr_f, bar_f);
                end
            end
        end
        if (xfer_s === 1'b1) begin
            n_tests++;
            if (q_s.size() == 0) begin
                n_fail++;
                $display("FAIL xfer_s_unexpected: got addr=%h bar=%b, expected no transfer", addr_s, bar_s);
            end else begin
                e_mon = q_s.pop_front();
                if ({addr_s, bar_s} !== {e_mon.addr, e_mon.bar}) begin
                    n_fail++;
                    $display("FAIL xfer_s: got addr=%h bar=%b, expected addr=%h bar=%b",
                             addr_s, bar_s, e_mon.addr, e_mon.bar);
                end else begin
                    $display("[TB] xfer slow addr=%h bar=%b", addr_s, bar_s);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_n = 1'b1; irdy_n = 1'b1; frame_ns = 1'b1; irdy_ns = 1'b1;
        ad = 32'h0; cbe_n = 4'h0; be_ready = 1'b1;
        cyc();
        cyc();
        n_tests++;
        if ({devsel_f, trdy_f, stop_f, bar_f, busy_f, addr_f, cmd_f} !== {1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_fast: got dev=%b trdy=%b stop=%b bar=%b busy=%b addr=%h cmd=%h, expected 1 1 1 00 0 0 0",
                     devsel_f, trdy_f, stop_f, bar_f, busy_f, addr_f, cmd_f);
        end
        n_tests++;
        if ({devsel_s, trdy_s, stop_s, bar_s, busy_s, addr_s, cmd_s} !== {1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_slow: got dev=%b trdy=%b stop=%b bar=%b busy=%b addr=%h cmd=%h, expected 1 1 1 00 0 0 0",
                     devsel_s, trdy_s, stop_s, bar_s, busy_s, addr_s, cmd_s);
        end
        rst = 1'b0;
        cyc();
        $display("[TB] reset done");
    endtask

    // BAR0 is the low word of BAR_BASE (0x1000_0000), so this access claims bar_hit[0].
    task automatic test_single();
        logic [4:0] exp_f, exp_s;
        frame_n = 1'b0; frame_ns = 1'b0; irdy_n = 1'b1; irdy_ns = 1'b1;
        ad = 32'h1000_0040; cbe_n = 4'h6; be_ready = 1'b1;
        q_f.push_back('{addr: 32'h1000_0040, bar: 2'b01});
        q_s.push_back('{addr: 32'h1000_0040, bar: 2'b01});
        for (int k = 0; k <= 4; k++) begin
            cyc();
            exp_f = {(k <= 1) ? 1'b0 : 1'b1, (k == 1) ? 1'b0 : 1'b1, (k <= 1) ? 2'b01 : 2'b00, (k <= 1) ? 1'b1 : 1'b0};
            exp_s = {(k == 2 || k == 3) ? 1'b0 : 1'b1, (k == 3) ? 1'b0 : 1'b1, (k <= 3) ? 2'b01 : 2'b00, (k <= 3) ? 1'b1 : 1'b0};
            n_tests++;
            if ({devsel_f, trdy_f, bar_f, busy_f} !== exp_f) begin
                n_fail++;
                $display("FAIL single_fast_E%0d: got dev/trdy/bar/busy=%b, expected %b", k, {devsel_f, trdy_f, bar_f, busy_f}, exp_f);
            end
            n_tests++;
            if ({devsel_s, trdy_s, bar_s, busy_s} !== exp_s) begin
                n_fail++;
                $display("FAIL single_slow_E%0d: got dev/trdy/bar/busy=%b, expected %b", k, {devsel_s, trdy_s, bar_s, busy_s}, exp_s);
            end
            if (k == 0) begin
                n_tests++;
                if ({addr_f, cmd_f} !== {32'h1000_0040, 4'h6}) begin
                    n_fail++;
                    $display("FAIL single_latch: got addr=%h cmd=%h, expected 10000040 6", addr_f, cmd_f);
                end
                frame_n = 1'b1; frame_ns = 1'b1; irdy_n = 1'b0; irdy_ns = 1'b0; ad = 32'h0;
            end
        end
        n_tests++;
        if ({addr_f, addr_s} !== {32'h1000_0044, 32'h1000_0044}) begin
            n_fail++;
            $display("FAIL single_addr_inc: got fast=%h slow=%h, expected 10000044 10000044", addr_f, addr_s);
        end
        irdy_n = 1'b1; irdy_ns = 1'b1;
        cyc();
        n_tests++;
        if (q_f.size() + q_s.size() != 0) begin
            n_fail++;
            $display("FAIL single_pending: got %0d queued transfers, expected 0", q_f.size() + q_s.size());
        end
        $display("[TB] single-phase read fast+slow done");
    endtask

    task automatic test_no_hit();
        frame_n = 1'b0; irdy_n = 1'b1; ad = 32'h3000_0000; cbe_n = 4'h6;
        cyc();
        n_tests++;
        if ({busy_f, devsel_f, bar_f, addr_f, cmd_f} !== {1'b1, 1'b1, 2'b00, 32'h3000_0000, 4'h6}) begin
            n_fail++;
            $display("FAIL nohit_addr: got busy=%b dev=%b bar=%b addr=%h cmd=%h, expected 1 1 00 30000000 6",
                     busy_f, devsel_f, bar_f, addr_f, cmd_f);
        end
        frame_n = 1'b1; irdy_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_tests++;
            if ({busy_f, devsel_f, trdy_f} !== 3'b111) begin
                n_fail++;
                $display("FAIL nohit_hold%0d: got busy/dev/trdy=%b, expected 111", k, {busy_f, devsel_f, trdy_f});
            end
        end
        irdy_n = 1'b1;
        cyc();
        n_tests++;
        if ({busy_f, devsel_f} !== 2'b01) begin
            n_fail++;
            $display("FAIL nohit_idle: got busy/dev=%b, expected 01", {busy_f, devsel_f});
        end
        $display("[TB] no-hit transaction done");
    endtask

    task automatic test_cmd_filter();
        frame_n = 1'b0; irdy_n = 1'b1; ad = 32'h0000_2010; cbe_n = 4'hA;
        cyc();
        n_tests++;
        if ({devsel_f, bar_f, busy_f, cmd_f} !== {1'b1, 2'b00, 1'b1, 4'hA}) begin
            n_fail++;
            $display("FAIL cmd_filter: got dev=%b bar=%b busy=%b cmd=%h, expected 1 00 1 a", devsel_f, bar_f, busy_f, cmd_f);
        end
        frame_n = 1'b1;
        cyc();
        n_tests++;
        if (busy_f !== 1'b0) begin
            n_fail++;
            $display("FAIL cmd_filter_idle: got busy=%b, expected 0", busy_f);
        end
        $display("[TB] disabled command done");
    endtask

    task automatic test_burst();
        logic pat [5];
        int   pi, done, guard;
        logic x;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        frame_n = 1'b0; irdy_n = 1'b1; ad = 32'h0000_2000; cbe_n = 4'h7; be_ready = 1'b1;
        for (int i = 0; i < 4; i++) q_f.push_back('{addr: 32'h0000_2000 + 32'(4 * i), bar: 2'b10});
        cyc();
        n_tests++;
        if ({devsel_f, bar_f} !== 3'b010) begin
            n_fail++;
            $display("FAIL burst_claim: got dev/bar=%b, expected 010", {devsel_f, bar_f});
        end
        pi = 0; done = 0; guard = 0;
        while (busy_f && guard < 20) begin
            frame_n  = (done == 3) ? 1'b1 : 1'b0;
            irdy_n   = 1'b0;
            be_ready = pat[(pi < 5) ? pi : 4];
            pi++;
            #1 x = xfer_f;
            cyc();
            if (x) done++;
            guard++;
        end
        n_tests++;
        if ({32'(done), addr_f, devsel_f, trdy_f, busy_f} !== {32'd4, 32'h0000_2010, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL burst_end: got xfers=%0d addr=%h dev=%b trdy=%b busy=%b, expected 4 00002010 1 1 0",
                     done, addr_f, devsel_f, trdy_f, busy_f);
        end
        irdy_n = 1'b1;

        // Second burst, reset after two transfers.
        frame_n = 1'b0; ad = 32'h0000_2000; cbe_n = 4'h7; be_ready = 1'b1;
        q_f.push_back('{addr: 32'h0000_2000, bar: 2'b10});
        q_f.push_back('{addr: 32'h0000_2004, bar: 2'b10});
        cyc();
        done = 0; guard = 0;
        while (done < 2 && guard < 10) begin
            frame_n = 1'b0; irdy_n = 1'b0;
            #1 x = xfer_f;
            cyc();
            if (x) done++;
            guard++;
        end
        n_tests++;
        if ({busy_f, devsel_f, addr_f} !== {1'b1, 1'b0, 32'h0000_2008}) begin
            n_fail++;
            $display("FAIL burst_mid: got busy=%b dev=%b addr=%h, expected 1 0 00002008", busy_f, devsel_f, addr_f);
        end
        rst = 1'b1; irdy_n = 1'b1;
        cyc();
        n_tests++;
        if ({devsel_f, trdy_f, stop_f, bar_f, busy_f, addr_f, cmd_f} !== {1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL burst_reset: got dev=%b trdy=%b stop=%b bar=%b busy=%b addr=%h cmd=%h, expected 1 1 1 00 0 0 0",
                     devsel_f, trdy_f, stop_f, bar_f, busy_f, addr_f, cmd_f);
        end
        rst = 1'b0; frame_n = 1'b1;
        cyc();
        n_tests++;
        if (q_f.size() != 0) begin
            n_fail++;
            $display("FAIL burst_pending: got %0d queued transfers, expected 0", q_f.size());
        end
        $display("[TB] burst and mid-burst reset done");
    endtask

    task automatic test_back_to_back();
        frame_n = 1'b0; irdy_n = 1'b1; ad = 32'h1000_0000; cbe_n = 4'h6; be_ready = 1'b1;
        q_f.push_back('{addr: 32'h1000_0000, bar: 2'b01});
        q_f.push_back('{addr: 32'h0000_2004, bar: 2'b10});
        cyc();
        frame_n = 1'b1; irdy_n = 1'b0;
        cyc();
        cyc();
        n_tests++;
        if ({busy_f, devsel_f} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_first_end: got busy/dev=%b, expected 01", {busy_f, devsel_f});
        end
        frame_n = 1'b0; irdy_n = 1'b1; ad = 32'h0000_2004; cbe_n = 4'h2;
        cyc();
        n_tests++;
        if ({devsel_f, bar_f, busy_f, addr_f, cmd_f} !== {1'b0, 2'b10, 1'b1, 32'h0000_2004, 4'h2}) begin
            n_fail++;
            $display("FAIL b2b_second_claim: got dev=%b bar=%b busy=%b addr=%h cmd=%h, expected 0 10 1 00002004 2",
                     devsel_f, bar_f, busy_f, addr_f, cmd_f);
        end
        frame_n = 1'b1; irdy_n = 1'b0;
        cyc();
        cyc();
        irdy_n = 1'b1;
        cyc();
        n_tests++;
        if ({q_f.size() == 0, busy_f} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_end: got pending=%0d busy=%b, expected 0 0", q_f.size(), busy_f);
        end
        $display("[TB] back-to-back done");
    endtask

    task automatic test_retry();
        frame_n = 1'b0; irdy_n = 1'b1; ad = 32'h0000_2000; cbe_n = 4'h6; be_ready = 1'b0;
        cyc();
        irdy_n = 1'b0;
`ifdef PCI_TARGET_RETRY_EN
        for (int k = 1; k <= 17; k++) begin
            cyc();
            n_tests++;
            if ({stop_f, trdy_f, devsel_f} !== {(k >= 16) ? 1'b0 : 1'b1, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL retry_E%0d: got stop/trdy/dev=%b, expected %b", k, {stop_f, trdy_f, devsel_f},
                         {(k >= 16) ? 1'b0 : 1'b1, 1'b1, 1'b0});
            end
        end
        frame_n = 1'b1;
        cyc();
        n_tests++;
        if ({stop_f, devsel_f, bar_f, busy_f} !== {1'b1, 1'b1, 2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL retry_release: got stop=%b dev=%b bar=%b busy=%b, expected 1 1 00 0", stop_f, devsel_f, bar_f, busy_f);
        end
        irdy_n = 1'b1;
        cyc();
`else
        for (int k = 1; k <= 20; k++) begin
            cyc();
            n_tests++;
            if ({stop_f, trdy_f, devsel_f} !== 3'b110) begin
                n_fail++;
                $display("FAIL wait_E%0d: got stop/trdy/dev=%b, expected 110", k, {stop_f, trdy_f, devsel_f});
            end
        end
        q_f.push_back('{addr: 32'h0000_2000, bar: 2'b10});
        frame_n = 1'b1; be_ready = 1'b1;
        cyc();
        cyc();
        n_tests++;
        if ({busy_f, addr_f, q_f.size() == 0} !== {1'b0, 32'h0000_2004, 1'b1}) begin
            n_fail++;
            $display("FAIL wait_end: got busy=%b addr=%h pending=%0d, expected 0 00002004 0", busy_f, addr_f, q_f.size());
        end
        irdy_n = 1'b1;
        cyc();
`endif
        $display("[TB] stalled first phase done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_no_hit();
        test_cmd_filter();
        test_burst();
        test_back_to_back();
        test_retry();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
